// File: rtl/ones_pkg.sv
// Shared types and helpers for the fixed-popcount pattern generator.
// Holds the FSM state type and the final-pattern helper.
package ones_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CW = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD,
        DONE
    } gen_state_t;

    // Last word of the sequence: k ones packed into the MSBs of a w-bit word.
    function automatic logic [15:0] top_pattern(
        input int unsigned k,
        input int unsigned w
    );
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if ((i < int'(w)) && (i >= int'(w) - int'(k))) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ones_popcount.sv
// Combinational population count of a WIDTH-bit word.
// Result width CW is wide enough to hold WIDTH itself.
module ones_popcount #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count
);

    // Sum every bit of the input word.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CW'(i_data[i]);
        end
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates all WIDTH-bit words with exactly k set bits, ascending,
// one word per valid/ready handshake.
module ones_pattern_gen
    import ones_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CW-1:0]    target_count,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] emitted
);

    gen_state_t       r_state;
    gen_state_t       w_state;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] w_cand;
    logic [CW-1:0]    r_k;
    logic [CW-1:0]    w_k;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data;
    logic             r_valid;
    logic             w_valid;
    logic [WIDTH-1:0] r_emitted;
    logic [WIDTH-1:0] w_emitted;
    logic [CW-1:0]    w_pop;
    logic [15:0]      w_top16;
    logic             w_last;

    ones_popcount #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_pop (
        .i_data  (r_cand),
        .o_count (w_pop)
    );

    assign w_top16    = top_pattern(32'(r_k), WIDTH);
    assign w_last     = r_valid && (r_data == w_top16[WIDTH-1:0]);

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign last       = w_last;
    assign emitted    = r_emitted;
    assign busy       = (r_state == SCAN) || (r_state == HOLD);
    assign done       = (r_state == DONE);
    assign error      = (r_state == DONE) && (32'(r_k) > WIDTH);

    // Next-state and datapath updates for the scan/hold handshake loop.
    always_comb begin
        w_state   = r_state;
        w_cand    = r_cand;
        w_k       = r_k;
        w_data    = r_data;
        w_valid   = r_valid;
        w_emitted = r_emitted;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_k       = target_count;
                    w_cand    = '0;
                    w_emitted = '0;
                    if (32'(target_count) > WIDTH) begin
                        w_state = DONE;
                    end else begin
                        w_state = SCAN;
                    end
                end
            end
            SCAN: begin
                if (w_pop == r_k) begin
                    w_data  = r_cand;
                    w_valid = 1'b1;
                    w_state = HOLD;
                end else if (&r_cand) begin
                    w_state = DONE;
                end else begin
                    w_cand = r_cand + WIDTH'(1);
                end
            end
            HOLD: begin
                if (data_ready) begin
                    w_emitted = r_emitted + WIDTH'(1);
                    w_valid   = 1'b0;
                    if (w_last) begin
                        w_state = DONE;
                    end else begin
                        w_cand  = r_cand + WIDTH'(1);
                        w_state = SCAN;
                    end
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State, candidate and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cand    <= '0;
            r_k       <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_emitted <= '0;
        end else begin
            r_state   <= w_state;
            r_cand    <= w_cand;
            r_k       <= w_k;
            r_data    <= w_data;
            r_valid   <= w_valid;
            r_emitted <= w_emitted;
        end
    end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen (WIDTH=8).
// Reference sequence is built by brute-force enumeration of all words.
module tb_ones_pattern_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target_count = '0;
    logic       data_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       last;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] emitted;

    ones_pattern_gen #(.WIDTH(8), .CW(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .target_count (target_count),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .last         (last),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .emitted      (emitted)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_q[$];
    int   idx = 0;
    int   mk = 0;
    logic chk_en = 1'b0;
    logic done_seen = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      nm, act, act, exp, exp);
    endtask

    function automatic void build(input int k);
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            if ($countones(v) == k) exp_q.push_back(v);
        end
        idx = 0;
        mk  = k;
    endfunction

    // Per-cycle comparison against the enumerated sequence.
    always @(negedge clk) begin
        if (chk_en) begin
            if (data_valid) begin
                chk("in_range", int'(idx < exp_q.size()), 1);
                if (idx < exp_q.size()) chk("data_out", data_out, exp_q[idx]);
                chk("last", last, int'(idx == exp_q.size() - 1));
                chk("emitted", emitted, idx);
                chk("busy", busy, 1);
                if (data_ready) idx++;
            end else begin
                chk("last_nv", last, 0);
            end
            if (done) begin
                chk("done_valid", data_valid, 0);
                chk("done_error", error, int'(mk > 8));
                chk("done_emitted", emitted, exp_q.size());
                chk("done_count", idx, exp_q.size());
                chk("done_busy", busy, 0);
                done_seen = 1'b1;
                chk_en    = 1'b0;
            end else begin
                chk("error_nd", error, 0);
            end
        end
    end

    task automatic zero_check(input string tag);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_valid"}, data_valid, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_emitted"}, emitted, 0);
    endtask

    // mode: 0 plain, 1 stall on 2nd word, 2 start during HOLD, 3 reset mid-run
    task automatic run(input int k, input int mode);
        bit stalled = 0;
        bit poked = 0;
        bit after = 0;
        build(k);
        done_seen = 1'b0;
        chk_en    = 1'b1;
        start        = 1'b1;
        target_count = k[3:0];
        @(posedge clk); #1;
        start = 1'b0;
        if (k == 9) begin
            chk("k9_done", done, 1);
            chk("k9_error", error, 1);
            chk("k9_valid", data_valid, 0);
        end
        if (k == 0) chk("k0_early", data_valid, 0);
        for (int c = 1; c < 4000 && !done_seen; c++) begin
            @(posedge clk); #1;
            if (k == 0 && c == 1) begin
                chk("k0_valid", data_valid, 1);
                chk("k0_data", data_out, 0);
                chk("k0_last", last, 1);
            end
            if (k == 2 && c == 3) chk("k2_pre", data_valid, 0);
            if (k == 2 && c == 4) begin
                chk("k2_lat", data_valid, 1);
                chk("k2_first", data_out, 'h03);
            end
            if (mode == 1 && !stalled && data_valid && idx == 1) begin
                stalled    = 1;
                data_ready = 1'b0;
                chk("stall_data", data_out, 'h0B);
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_hold", data_out, 'h0B);
                    chk("stall_valid", data_valid, 1);
                    chk("stall_emit", emitted, 1);
                end
                data_ready = 1'b1;
            end
            if (mode == 1 && !after && data_valid && idx == 2) begin
                after = 1;
                chk("after_stall", data_out, 'h0D);
            end
            if (mode == 2 && !poked && data_valid && idx == 3) begin
                poked        = 1;
                start        = 1'b1;
                target_count = 4'd5;
                @(posedge clk); #1;
                start = 1'b0;
                chk("poke_busy", busy, 1);
            end
            if (mode == 3 && data_valid && idx == 2) begin
                chk_en  = 1'b0;
                #2;
                reset_n = 1'b0;
                #1;
                zero_check("mid_rst");
                @(posedge clk); #1;
                reset_n = 1'b1;
                return;
            end
        end
        if (!done_seen) chk("timeout", 0, 1);
        @(posedge clk); #1;
        chk("end_emitted", emitted, exp_q.size());
        chk("end_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        zero_check("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        build(2);
        chk("model_k2_n", exp_q.size(), 28);
        chk("model_k2_first", exp_q[0], 'h03);
        chk("model_k2_2nd", exp_q[1], 'h05);
        chk("model_k2_last", exp_q[27], 'hC0);
        build(3);
        chk("model_k3_n", exp_q.size(), 56);
        chk("model_k3_2nd", exp_q[1], 'h0B);
        run(2, 0);
        chk("k2_total", emitted, 28);
        run(0, 0);
        chk("k0_total", emitted, 1);
        run(8, 0);
        chk("k8_total", emitted, 1);
        run(9, 0);
        chk("k9_total", emitted, 0);
        run(3, 1);
        run(3, 2);
        chk("poke_total", emitted, 56);
        run(4, 3);
        run(1, 0);
        chk("k1_total", emitted, 8);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
